// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and widths for the FIFO read-side drain controller.
//   rd_state_t   FSM encoding (IDLE / RUN / DRAIN)
//   WIDX_W       word-index width, sized for the largest legal burst (256)
//   FRAME_CNT_W  completed-frame counter width
//   STAT_W       width of the optional statistics counters
//   sat_inc      saturating increment for the statistics counters
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int MAX_BURST   = 256;
  localparam int WIDX_W      = $clog2(MAX_BURST);
  localparam int FRAME_CNT_W = 16;
  localparam int STAT_W      = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry {last,data} skid buffer between the FIFO pop and the
// registered output stream. Entry 0 is always the head.
//   clk, rst     clock, synchronous active-high reset
//   push         write {push_last, push_data} (ignored when full)
//   pop          remove the head (ignored when empty)
//   occ          occupancy 0..2
//   head_last    last flag of the head entry
//   head_data    data of the head entry (0 after reset)
module fifo_rd_skid #(
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_last,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic             head_last,
  output logic [DSIZE-1:0] head_data
);

  logic [DSIZE:0] ent0, ent1;
  logic           do_push, do_pop;

  assign do_pop  = pop & (occ != 2'd0);
  assign do_push = push & (occ != 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          // Simultaneous push/pop only reaches here with occ==1 (push is
          // blocked at 2), so the new word simply replaces the head.
          ent0 <= {push_last, push_data};
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) ent0 <= {push_last, push_data};
          else             ent1 <= {push_last, push_data};
          occ <= occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_last = ent0[DSIZE];
  assign head_data = ent0[DSIZE-1:0];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side drain controller for the dual-clock FIFO (rclk
// domain). Pops words from a first-word-fall-through FIFO whenever there is
// buffer room, frames them into BURST_LEN-word bursts and presents them on a
// registered valid/ready stream with a last flag.
// Optional feature macro: FIFO_RD_STATS_EN adds pop_cnt / stall_cnt.
// Ports:
//   rclk, rrst            clock, synchronous active-high reset
//   rd_en                 run enable (stop honoured at the frame boundary)
//   fifo_rdata/rempty     FIFO head word / empty flag
//   fifo_error_r          FIFO read-side error, latched into err_sticky
//   fifo_rinc             pop strobe to the FIFO (combinational)
//   m_data/valid/last     output stream, m_ready is the downstream accept
//   err_clr/err_sticky    sticky error clear / flag (set wins)
//   frame_cnt             completed frames, wraps
//   busy                  FSM active or words still buffered
//   pop_cnt, stall_cnt    (FIFO_RD_STATS_EN) saturating pop / stall counters
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE     = 16,
  parameter int BURST_LEN = 16
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rd_en,
  input  logic [DSIZE-1:0]       fifo_rdata,
  input  logic                   fifo_rempty,
  input  logic                   fifo_error_r,
  output logic                   fifo_rinc,
  output logic [DSIZE-1:0]       m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  input  logic                   err_clr,
  output logic                   err_sticky,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0]      pop_cnt,
  output logic [STAT_W-1:0]      stall_cnt
`endif
);

  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(BURST_LEN - 1);

  rd_state_t         state, state_nxt;
  logic [WIDX_W-1:0] widx;
  logic [1:0]        occ;
  logic              at_last, can_pop, head_last, accept;

  assign at_last = (widx == WIDX_LAST);
  assign can_pop = ~fifo_rempty & (occ != 2'd2) & ~rrst;
  assign accept  = m_valid & m_ready;

  // State register
  always_ff @(posedge rclk) begin
    if (rrst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rd_en) state_nxt = ST_RUN;
      ST_RUN:   if (!rd_en) state_nxt = (widx == '0) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (fifo_rinc && at_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: in RUN, a stop request at a frame boundary must not start a
  // new frame, so the pop is suppressed on that exit cycle.
  always_comb begin
    fifo_rinc = 1'b0;
    case (state)
      ST_RUN:   fifo_rinc = can_pop & (rd_en | (widx != '0));
      ST_DRAIN: fifo_rinc = can_pop;
      default:  fifo_rinc = 1'b0;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst)           widx <= '0;
    else if (fifo_rinc) widx <= at_last ? '0 : widx + WIDX_W'(1);
  end

  fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .clk       (rclk),
    .rst       (rrst),
    .push      (fifo_rinc),
    .push_last (at_last),
    .push_data (fifo_rdata),
    .pop       (m_ready),
    .occ       (occ),
    .head_last (head_last),
    .head_data (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid & head_last;
  assign busy    = (state != ST_IDLE) | m_valid;

  always_ff @(posedge rclk) begin
    if (rrst)                  frame_cnt <= '0;
    else if (accept && m_last) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
  end

  // Set has priority over clear so an error coinciding with a clear is kept.
  always_ff @(posedge rclk) begin
    if (rrst)              err_sticky <= 1'b0;
    else if (fifo_error_r) err_sticky <= 1'b1;
    else if (err_clr)      err_sticky <= 1'b0;
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fifo_rinc)          pop_cnt   <= sat_inc(pop_cnt);
      if (m_valid && !m_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: self-checking bench for fifo_rd_ctrl (BURST_LEN=4).
// The reference treats the output as "every word ever written to the FIFO,
// in order, minus words lost at reset", tagging every BURST_LEN-th word
// since reset as last; buffered depth is simply pops minus accepts.
module tb_fifo_rd_ctrl;
  import fifo_rd_pkg::*;

  localparam int DSIZE = 16;
  localparam int BL    = 4;

  logic             rclk = 1'b0;
  logic             rrst, rd_en, fifo_rempty, fifo_error_r, fifo_rinc;
  logic             m_valid, m_last, m_ready, err_clr, err_sticky, busy;
  logic [DSIZE-1:0] fifo_rdata, m_data;
  logic [15:0]      frame_cnt;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]      pop_cnt, stall_cnt;
`endif

  fifo_rd_ctrl #(.DSIZE(DSIZE), .BURST_LEN(BL)) dut (
    .rclk(rclk), .rrst(rrst), .rd_en(rd_en), .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty), .fifo_error_r(fifo_error_r), .fifo_rinc(fifo_rinc),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .err_clr(err_clr), .err_sticky(err_sticky), .frame_cnt(frame_cnt), .busy(busy)
`ifdef FIFO_RD_STATS_EN
    , .pop_cnt(pop_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  // Reference state
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] hist[$];
  int pop_n, acc_n, base, fr;
  logic err_m;
  int tests, fails;

  typedef struct {
    logic err;
    logic clr;
    logic exp;
  } err_vec_t;
  err_vec_t ev[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DSIZE-1:0] v);
    fifo_q.push_back(v);
    hist.push_back(v);
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance the reference.
  task automatic step(input logic en, input logic rdy, input logic err,
                      input logic clr, input logic rst);
    int   buffered;
    logic p, a;
    rd_en = en; m_ready = rdy; fifo_error_r = err; err_clr = clr; rrst = rst;
    fifo_rempty = (fifo_q.size() == 0);
    fifo_rdata  = fifo_rempty ? '0 : fifo_q[0];
    #1;
    buffered = pop_n - acc_n;
    chk("m_valid", m_valid, buffered != 0);
    if (buffered != 0) begin
      chk("m_data", m_data, hist[acc_n]);
      chk("m_last", m_last, ((acc_n - base) % BL) == BL - 1);
    end
    chk("frame_cnt", frame_cnt, 16'(fr));
    chk("err_sticky", err_sticky, err_m);
    chk("busy_buf", busy | (buffered == 0), 1);
    chk("rinc_full", fifo_rinc & (buffered >= 2), 0);
    chk("rinc_empty", fifo_rinc & fifo_rempty, 0);
    if (rst) chk("rinc_rst", fifo_rinc, 0);
    p = fifo_rinc;
    a = m_valid & m_ready & (buffered != 0);
    @(posedge rclk); #1;
    if (p && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pop_n++;
    end
    if (rst) begin
      acc_n = pop_n; base = pop_n; fr = 0; err_m = 1'b0;
    end else begin
      if (a) begin
        if (((acc_n - base) % BL) == BL - 1) fr++;
        acc_n++;
      end
      err_m = err ? 1'b1 : (clr ? 1'b0 : err_m);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cur, maxrun, p0, a0, fr0, k;
    tests = 0; fails = 0;
    pop_n = 0; acc_n = 0; base = 0; fr = 0; err_m = 1'b0;
    ev[0] = '{1'b1, 1'b0, 1'b1};   // error pulse sets
    ev[1] = '{1'b0, 1'b0, 1'b1};   // holds
    ev[2] = '{1'b1, 1'b1, 1'b1};   // set wins over clear
    ev[3] = '{1'b0, 1'b1, 1'b0};   // clear alone
    ev[4] = '{1'b0, 1'b0, 1'b0};
    ev[5] = '{1'b1, 1'b0, 1'b1};
    ev[6] = '{1'b0, 1'b1, 1'b0};

    // Reset values
    rrst = 1'b1; rd_en = 1'b0; m_ready = 1'b0; fifo_error_r = 1'b0; err_clr = 1'b0;
    fifo_rempty = 1'b1; fifo_rdata = '0;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rinc", fifo_rinc, 0);
    step(0, 0, 0, 0, 0);
    chk("idle_busy", busy, 0);

    // Basic frame: 1..4, four consecutive valid cycles, one frame
    for (int i = 1; i <= 4; i++) push(16'(i));
    cur = 0; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, 0);
      if (m_valid) cur++; else cur = 0;
      if (cur > maxrun) maxrun = cur;
    end
    chk("basic_valid_run", maxrun, 4);
    chk("basic_frames", frame_cnt, 1);

    // Backpressure: ready pattern 1,0,0,...
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    a0 = acc_n;
    for (int i = 0; i < 40; i++) step(1, (i % 3) == 0, 0, 0, 0);
    chk("bp_words", acc_n - a0, 8);

    // Mid-frame stop after 2 pops
    for (int i = 0; i < 6; i++) push(16'h0200 + 16'(i));
    p0 = pop_n;
    for (k = 0; k < 20 && (pop_n - p0) < 2; k++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0);
    chk("stop_pops", pop_n - p0, 4);
    chk("stop_busy", busy, 0);
    chk("stop_rinc", fifo_rinc, 0);

    // Empty stall: the 2 leftover words, a 5-cycle gap, then 2 more
    p0 = pop_n; a0 = acc_n; fr0 = fr;
    for (k = 0; k < 20 && (pop_n - p0) < 2; k++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    chk("stall_gap_valid", m_valid, 0);
    push(16'h0300); push(16'h0301);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    chk("stall_words", acc_n - a0, 4);
    chk("stall_frames", frame_cnt, 16'(fr0 + 1));

    // Reset mid-frame with two words buffered
    for (int i = 0; i < 6; i++) push(16'h0400 + 16'(i));
    for (k = 0; k < 20 && (pop_n - acc_n) < 2; k++) step(1, 0, 0, 0, 0);
    chk("rst_mid_occ2", pop_n - acc_n, 2);
    step(1, 0, 0, 0, 1);
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_frames", frame_cnt, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
    chk("rst_next_frame", frame_cnt, 1);

    // Error latch vectors
    foreach (ev[i]) begin
      step(1, 1, ev[i].err, ev[i].clr, 0);
      chk("err_vec", err_sticky, ev[i].exp);
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 20) push(16'($urandom));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 199) == 0);
    end

    // Drain: stop, keep data available so an open frame can complete
    for (k = 0; k < 200 && busy; k++) begin
      if (fifo_q.size() < 4) push(16'($urandom));
      step(0, 1, 0, 0, 0);
    end
    chk("drain_idle", busy, 0);
    chk("drain_boundary", (pop_n - base) % BL, 0);
    p0 = pop_n;
    push(16'hBEEF);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    chk("idle_no_pop", pop_n - p0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
